uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Controller FSM that sequences the UART transmit datapath (serializer, parity calculator, TX output mux) through start, data, parity and stop bits.
- Drives `ser_en`, `load_en` and `mux_sel` into the datapath and consumes `ser_done` from it.
- Adds 1/2 stop-bit support, back-to-back frames without an idle gap, busy/frame-done status, and a bit-count cross-check against `ser_done`.
- Runs in the TX (baud) clock domain: one clock cycle equals one bit time.

Parameters:
- WIDTH, 8, data bits per frame; sizes the internal bit counter to $clog2(WIDTH+1) bits.

Ports:
- CLK  in  1  TX/baud clock
- RST  in  1  asynchronous active-low reset
- DATA_VALID  in  1  parallel data available; consumed on the edge where `load_en`=1
- PAR_EN  in  1  parity enable; latched on load
- STOP2  in  1  0 = one stop bit, 1 = two stop bits; latched on load
- ser_done  in  1  serializer flag, high during the cycle the last data bit is presented
- ser_en  out  1  serializer shift enable
- load_en  out  1  load P_DATA into serializer and parity block on this edge
- mux_sel  out  2  0 = start, 1 = data, 2 = idle/stop, 3 = parity
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse in the last stop-bit cycle
- frame_err  out  1  bit-count/`ser_done` mismatch in the current frame

Behaviour:
- Reset (async, RST=0): state IDLE, bit counter 0, latched parity enable and STOP2 cleared, `busy`=0, `frame_err`=0.
  - Combinational outputs in IDLE: `mux_sel`=2, `ser_en`=0, `frame_done`=0, `load_en`=DATA_VALID.
  - Reset asserted mid-frame forces the TX line high (`mux_sel`=2) immediately, with no clock required.
- States and outputs (Moore, except `load_en`, which is Mealy):
  - IDLE: `mux_sel`=2, `busy`=0.
  - START: `mux_sel`=0, `busy`=1.
  - DATA: `mux_sel`=1, `ser_en`=1, `busy`=1; bit counter increments each cycle.
  - PARITY: `mux_sel`=3, `busy`=1.
  - STOP1: `mux_sel`=2, `busy`=1.
  - STOP2: `mux_sel`=2, `busy`=1.
- Transitions:
  - IDLE -> START when DATA_VALID=1 (`load_en`=1 that cycle).
  - START -> DATA unconditionally; bit counter cleared.
  - DATA -> PARITY (latched parity enable=1) or STOP1 (=0), when `ser_done`=1 or bit counter = WIDTH-1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if latched STOP2=1; otherwise final stop.
  - Final stop cycle (STOP1 with STOP2=0, or STOP2): `frame_done`=1; `load_en`=DATA_VALID. If DATA_VALID=1 -> START (back-to-back, `busy` stays 1), else -> IDLE.
- Latency: DATA_VALID sampled at edge k gives start bit at cycle k+1 and data bit 0 at k+2. Frame length is 1+WIDTH+PAR_EN+(1 or 2) cycles.
- `load_en` is asserted only in IDLE or the final stop cycle, never mid-frame. DATA_VALID in any other state is ignored; the source must hold it.
- PAR_EN and STOP2 are latched only on `load_en`; changes mid-frame affect only the next frame.
- `frame_err` is set if:
  - `ser_done`=1 while bit counter != WIDTH-1, or
  - bit counter reaches WIDTH-1 without `ser_done`.
  - In both cases the DATA exit still occurs; there is no lockup.
  - `frame_err` holds until the next `load_en`, then clears.
- Bit counter wrap: it never exceeds WIDTH-1, because DATA always exits at WIDTH-1.
- Illegal state encodings recover to IDLE with `mux_sel`=2.

Decomposition:
- Shared package `uart_tx_pkg`:
  - state enum {IDLE, START, DATA, PARITY, STOP1, STOP2};
  - mux_sel constants MUX_START=2'd0, MUX_DATA=2'd1, MUX_IDLE_STOP=2'd2, MUX_PARITY=2'd3;
  - the same constants are used by the TX datapath.
- No sub-module: single FSM plus bit counter.
- Top-level UART TX instantiates uart_tx_ctrl next to the datapath.

Test Plan:
- WIDTH=8, PAR_EN=0, STOP2=0, single DATA_VALID pulse held for 1 cycle in IDLE:
  - -> `load_en`=1 that cycle;
  - `mux_sel` sequence 0, 1×8, 2;
  - `busy` high for 10 cycles;
  - `frame_done` on cycle 10;
  - `ser_done` is a model of the datapath, high on the 8th DATA cycle.
- PAR_EN=1, STOP2=1:
  - -> `mux_sel` sequence 0, 1×8, 3, 2, 2; 12-cycle frame;
  - `frame_done` only on the 2nd stop cycle.
- DATA_VALID held high for 3 frames:
  - -> `load_en` in each final stop cycle;
  - `busy` never drops; no IDLE cycle between frames.
- Toggle PAR_EN 1→0 during DATA:
  - -> the current frame still emits parity (`mux_sel`=3);
  - the next frame has none.
- Fault cases:
  - `ser_done` forced high on the 3rd DATA cycle -> exit to STOP1 next edge, `frame_err`=1, cleared on the next `load_en`;
  - `ser_done` stuck low -> exit after 8 DATA cycles with `frame_err`=1.
- Assert RST low during the 4th DATA cycle:
  - -> `mux_sel`=2 and `busy`=0 asynchronously;
  - after release with DATA_VALID=0, the controller stays in IDLE.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: controller state encoding
// and the TX output mux select codes used by both controller and datapath.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_e;

    localparam logic [1:0] MUX_START     = 2'd0;
    localparam logic [1:0] MUX_DATA      = 2'd1;
    localparam logic [1:0] MUX_IDLE_STOP = 2'd2;
    localparam logic [1:0] MUX_PARITY    = 2'd3;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the TX controller and its source/datapath.
// slave = controller side, master = source/datapath side.
interface uart_tx_ctrl_if;

    logic       DATA_VALID;
    logic       PAR_EN;
    logic       STOP2;
    logic       ser_done;
    logic       ser_en;
    logic       load_en;
    logic [1:0] mux_sel;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    modport master (
        output DATA_VALID, PAR_EN, STOP2, ser_done,
        input  ser_en, load_en, mux_sel, busy, frame_done, frame_err
    );

    modport slave (
        input  DATA_VALID, PAR_EN, STOP2, ser_done,
        output ser_en, load_en, mux_sel, busy, frame_done, frame_err
    );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX controller: sequences start, data, optional parity and one or two
// stop bits. One clock is one bit time. Back-to-back frames are loaded in the
// final stop cycle so the line never returns to idle between them.
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    uart_tx_ctrl_if.slave bus
);
    import uart_tx_pkg::*;

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP1  = STOP1;
    localparam logic [2:0] S_STOP2  = STOP2;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] bit_cnt;
    logic          par_lat;
    logic          stop2_lat;
    logic          err;
    logic          last_bit;
    logic          data_exit;
    logic          ser_en;
    logic          load_en;
    logic [1:0]    mux_sel;
    logic          busy;
    logic          frame_done;

    // DATA ends on the serializer flag or when our own count says so,
    // whichever comes first, so a broken ser_done can never lock us up.
    always_comb begin
        last_bit  = (bit_cnt == LAST_BIT);
        data_exit = bus.ser_done || last_bit;
    end

    // Next-state and outputs; load_en is the only input-dependent output.
    always_comb begin
        state_nxt  = S_IDLE;
        mux_sel    = MUX_IDLE_STOP;
        ser_en     = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        load_en    = 1'b0;
        case (state)
            S_IDLE: begin
                load_en   = bus.DATA_VALID;
                state_nxt = bus.DATA_VALID ? S_START : S_IDLE;
            end
            S_START: begin
                mux_sel   = MUX_START;
                busy      = 1'b1;
                state_nxt = S_DATA;
            end
            S_DATA: begin
                mux_sel   = MUX_DATA;
                ser_en    = 1'b1;
                busy      = 1'b1;
                state_nxt = !data_exit ? S_DATA : (par_lat ? S_PARITY : S_STOP1);
            end
            S_PARITY: begin
                mux_sel   = MUX_PARITY;
                busy      = 1'b1;
                state_nxt = S_STOP1;
            end
            S_STOP1: begin
                busy = 1'b1;
                if (stop2_lat) begin
                    state_nxt = S_STOP2;
                end else begin
                    frame_done = 1'b1;
                    load_en    = bus.DATA_VALID;
                    state_nxt  = bus.DATA_VALID ? S_START : S_IDLE;
                end
            end
            S_STOP2: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                load_en    = bus.DATA_VALID;
                state_nxt  = bus.DATA_VALID ? S_START : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; async reset puts the line back to idle-high at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Data bit counter: cleared in START, held on the exit cycle so it
    // never runs past WIDTH-1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                                bit_cnt <= '0;
        else if (state == S_START)               bit_cnt <= '0;
        else if (state == S_DATA && !data_exit)  bit_cnt <= bit_cnt + 1'b1;
    end

    // Frame options are captured only when a frame is loaded.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_lat   <= 1'b0;
            stop2_lat <= 1'b0;
        end else if (load_en) begin
            par_lat   <= bus.PAR_EN;
            stop2_lat <= bus.STOP2;
        end
    end

    // Cross-check: ser_done must coincide exactly with the last counted bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                                           err <= 1'b0;
        else if (load_en)                                   err <= 1'b0;
        else if (state == S_DATA && (bus.ser_done != last_bit)) err <= 1'b1;
    end

    assign bus.ser_en     = ser_en;
    assign bus.load_en    = load_en;
    assign bus.mux_sel    = mux_sel;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.frame_err  = err;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-list model predicts every output each cycle.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remaining mux values of the current frame, one entry per cycle.
    int q[$];
    int didx;
    bit merr;
    bit last_le;
    int rf;

    int tr_mux[$];
    int tr_busy[$];
    int tr_fd[$];
    int tr_err[$];
    int tr_le[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_tr();
        tr_mux.delete(); tr_busy.delete(); tr_fd.delete(); tr_err.delete(); tr_le.delete();
    endtask

    task automatic step(input bit dv, input bit pe, input bit s2, input int fault);
        bit sd;
        bit emp;
        bit early;
        bit e_le;
        bit e_busy;
        bit e_ser;
        bit e_fd;
        int e_mux;
        @(negedge clk);
        emp = (q.size() == 0);
        if (!emp && q[0] == int'(MUX_DATA)) begin
            case (fault)
                1:       sd = (didx == 2);
                2:       sd = 1'b0;
                default: sd = (didx == W - 1);
            endcase
        end else begin
            sd = ($urandom_range(0, 3) == 0);
        end
        bus.DATA_VALID = dv;
        bus.PAR_EN     = pe;
        bus.STOP2      = s2;
        bus.ser_done   = sd;
        #1;
        if (emp) begin
            e_mux = int'(MUX_IDLE_STOP); e_busy = 0; e_ser = 0; e_fd = 0; e_le = dv;
        end else begin
            e_mux  = q[0];
            e_busy = 1;
            e_ser  = (q[0] == int'(MUX_DATA));
            e_fd   = (q.size() == 1);
            e_le   = e_fd && dv;
        end
        chk("mux_sel",    bus.mux_sel,    e_mux);
        chk("busy",       bus.busy,       e_busy);
        chk("ser_en",     bus.ser_en,     e_ser);
        chk("frame_done", bus.frame_done, e_fd);
        chk("load_en",    bus.load_en,    e_le);
        chk("frame_err",  bus.frame_err,  merr);
        tr_mux.push_back(int'(bus.mux_sel));
        tr_busy.push_back(int'(bus.busy));
        tr_fd.push_back(int'(bus.frame_done));
        tr_err.push_back(int'(bus.frame_err));
        tr_le.push_back(int'(bus.load_en));
        @(posedge clk);
        if (!emp) begin
            early = 0;
            if (q[0] == int'(MUX_DATA)) begin
                if (didx == W - 1) begin
                    if (!sd) merr = 1;
                end else if (sd) begin
                    merr  = 1;
                    early = 1;
                end
                didx++;
            end
            void'(q.pop_front());
            if (early)
                while (q.size() > 0 && q[0] == int'(MUX_DATA)) void'(q.pop_front());
        end
        if (e_le) begin
            merr = 0;
            didx = 0;
            q.push_back(int'(MUX_START));
            repeat (W) q.push_back(int'(MUX_DATA));
            if (pe) q.push_back(int'(MUX_PARITY));
            q.push_back(int'(MUX_IDLE_STOP));
            if (s2) q.push_back(int'(MUX_IDLE_STOP));
        end
        last_le = e_le;
    endtask

    function automatic int count_eq(input int arr[$], input int lo, input int hi, input int v);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (arr[i] == v) c++;
        return c;
    endfunction

    initial begin
        int s1[10];
        int s2[12];
        bit found;
        n_cmp = 0; n_err = 0;
        didx = 0; merr = 0; last_le = 0; rf = 0;
        rst = 1'b0;
        bus.DATA_VALID = 0; bus.PAR_EN = 0; bus.STOP2 = 0; bus.ser_done = 0;
        #3;
        chk("rst_mux",   bus.mux_sel,    2);
        chk("rst_busy",  bus.busy,       0);
        chk("rst_err",   bus.frame_err,  0);
        chk("rst_ser",   bus.ser_en,     0);
        chk("rst_fd",    bus.frame_done, 0);
        chk("rst_le",    bus.load_en,    0);
        @(negedge clk);
        rst = 1'b1;

        // Basic frame, no parity, one stop bit
        clear_tr();
        step(1, 0, 0, 0);
        repeat (11) step(0, 0, 0, 0);
        s1 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 2};
        chk("t1_load", tr_le[0], 1);
        for (int i = 1; i <= 10; i++) chk("t1_mux_seq", tr_mux[i], s1[i-1]);
        chk("t1_busy_len", count_eq(tr_busy, 0, 11, 1), 10);
        chk("t1_fd_at10", tr_fd[10], 1);
        chk("t1_fd_count", count_eq(tr_fd, 0, 11, 1), 1);

        // Parity plus two stop bits
        clear_tr();
        step(1, 1, 1, 0);
        repeat (13) step(0, 0, 0, 0);
        s2 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 3, 2, 2};
        for (int i = 1; i <= 12; i++) chk("t2_mux_seq", tr_mux[i], s2[i-1]);
        chk("t2_busy_len", count_eq(tr_busy, 0, 13, 1), 12);
        chk("t2_fd_at12", tr_fd[12], 1);
        chk("t2_fd_count", count_eq(tr_fd, 0, 13, 1), 1);

        // Three back-to-back frames
        clear_tr();
        repeat (21) step(1, 0, 0, 0);
        repeat (11) step(0, 0, 0, 0);
        chk("t3_loads", count_eq(tr_le, 0, 31, 1), 3);
        chk("t3_busy_run", count_eq(tr_busy, 1, 30, 1), 30);
        chk("t3_idle_after", tr_busy[31], 0);

        // Parity enable dropped mid-frame affects only the next frame
        clear_tr();
        step(1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (7) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (11) step(0, 1, 1, 0);
        chk("t4_parity_at10", tr_mux[10], 3);
        chk("t4_parity_count", count_eq(tr_mux, 0, 22, 3), 1);
        chk("t4_fd_f2", tr_fd[21], 1);
        chk("t4_busy_run", count_eq(tr_busy, 1, 21, 1), 21);

        // Early ser_done on 3rd data bit
        clear_tr();
        step(1, 0, 0, 1);
        repeat (4) step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (11) step(0, 0, 0, 0);
        chk("t5_stop_at5", tr_mux[5], 2);
        chk("t5_fd_at5", tr_fd[5], 1);
        chk("t5_err_pre", tr_err[4], 0);
        chk("t5_err_set", tr_err[5], 1);
        chk("t5_err_clr", tr_err[6], 0);

        // ser_done stuck low
        clear_tr();
        step(1, 0, 0, 2);
        repeat (10) step(0, 0, 0, 2);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (11) step(0, 0, 0, 0);
        chk("t6_last_data", tr_mux[9], 1);
        chk("t6_stop", tr_mux[10], 2);
        chk("t6_err_set", tr_err[10], 1);
        chk("t6_err_hold", tr_err[11], 1);
        chk("t6_err_clr", tr_err[13], 0);

        // Asynchronous reset during the 4th data bit
        step(1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (q.size() > 0 && q[0] == int'(MUX_DATA) && didx == 3) begin
                found = 1;
                break;
            end
            step(0, 0, 0, 0);
        end
        chk("t7_reach_data4", found, 1);
        @(negedge clk);
        bus.DATA_VALID = 0; bus.ser_done = 0;
        #1;
        chk("t7_pre_mux", bus.mux_sel, 1);
        rst = 1'b0;
        #1;
        chk("t7_rst_mux",  bus.mux_sel,   2);
        chk("t7_rst_busy", bus.busy,      0);
        chk("t7_rst_ser",  bus.ser_en,    0);
        chk("t7_rst_err",  bus.frame_err, 0);
        q.delete(); merr = 0; didx = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_tr();
        repeat (4) step(0, 1, 1, 0);
        chk("t7_stay_idle", count_eq(tr_busy, 0, 3, 1), 0);

        // Randomized traffic with occasional ser_done faults
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rf);
            if (last_le) rf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
        end
        repeat (14) step(0, 0, 0, rf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
